// File: rtl/spi_pkg.sv
// Shared type definitions for the SPI slave.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      CONFIGURE    = 2'd1,
      TRANSFER     = 2'd2,
      TRANSFER_END = 2'd3
   } state_t;

endpackage

// File: rtl/spi_slave.sv
// SPI slave with synchronized pins, a one-word transmit holding register,
// and continuous framing while chip select stays low.
module spi_slave #(
   parameter int DATA_WIDTH = 8,
   parameter int CPOL       = 0,
   parameter int CPHA       = 0
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  spi_sclk,
   input  logic                  spi_cs_n,
   input  logic                  spi_mosi,
   output logic                  spi_miso,
   output logic                  spi_miso_oe,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy,
   output logic                  tx_underrun
);
   import spi_pkg::*;

   localparam int               CNT_W     = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
   localparam bit               POL       = (CPOL != 0);
   localparam bit               PHA       = (CPHA != 0);
   // Bit order in the synchronizer vectors: {sclk, cs_n, mosi}.
   localparam logic [2:0]       SYNC_INIT = {POL, 1'b1, 1'b0};

   logic [2:0] pin_in;
   logic [2:0] sync1_reg;
   logic [2:0] sync2_reg;
   logic [2:0] hist_reg;

   state_t                  state_reg;
   logic [CNT_W-1:0]        bit_cnt_reg;
   logic [DATA_WIDTH-2:0]   tx_shift_reg;
   logic [DATA_WIDTH-1:0]   rx_shift_reg;
   logic [DATA_WIDTH-1:0]   hold_reg;
   logic                    tx_ready_reg;
   logic                    miso_reg;
   logic                    oe_reg;
   logic [DATA_WIDTH-1:0]   rx_data_reg;
   logic                    rx_valid_reg;
   logic                    busy_reg;
   logic                    underrun_reg;

   logic sclk_rise, sclk_fall, lead_edge, trail_edge;
   logic sample_edge, shift_edge, cs_fall, cs_rise, cs_low, mosi_bit;
   logic [DATA_WIDTH-1:0] load_word;

   assign pin_in = {spi_sclk, spi_cs_n, spi_mosi};

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         sync1_reg <= SYNC_INIT;
         sync2_reg <= SYNC_INIT;
         hist_reg  <= SYNC_INIT;
      end else begin
         sync1_reg <= pin_in;
         sync2_reg <= sync1_reg;
         hist_reg  <= sync2_reg;
      end
   end

   assign sclk_rise   = sync2_reg[2] & ~hist_reg[2];
   assign sclk_fall   = ~sync2_reg[2] & hist_reg[2];
   assign lead_edge   = POL ? sclk_fall : sclk_rise;
   assign trail_edge  = POL ? sclk_rise : sclk_fall;
   assign sample_edge = PHA ? trail_edge : lead_edge;
   assign shift_edge  = PHA ? lead_edge : trail_edge;
   assign cs_fall     = ~sync2_reg[1] & hist_reg[1];
   assign cs_rise     = sync2_reg[1] & ~hist_reg[1];
   assign cs_low      = ~sync2_reg[1];
   // MOSI as seen alongside the pre-edge SCLK level, giving a cycle of hold margin.
   assign mosi_bit    = hist_reg[0];

   // An empty holding register loads zeros; a same-cycle capture never bypasses.
   assign load_word = tx_ready_reg ? '0 : hold_reg;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_reg    <= IDLE;
         bit_cnt_reg  <= '0;
         tx_shift_reg <= '0;
         rx_shift_reg <= '0;
         hold_reg     <= '0;
         tx_ready_reg <= 1'b1;
         miso_reg     <= 1'b0;
         oe_reg       <= 1'b0;
         rx_data_reg  <= '0;
         rx_valid_reg <= 1'b0;
         busy_reg     <= 1'b0;
         underrun_reg <= 1'b0;
      end else begin
         rx_valid_reg <= 1'b0;
         underrun_reg <= 1'b0;

         if (tx_valid && tx_ready_reg) begin
            hold_reg     <= tx_data;
            tx_ready_reg <= 1'b0;
         end

         case (state_reg)
            IDLE: begin
               if (cs_fall) begin
                  state_reg <= CONFIGURE;
                  busy_reg  <= 1'b1;
               end
            end

            CONFIGURE: begin
               tx_shift_reg <= load_word[DATA_WIDTH-2:0];
               if (tx_ready_reg) begin
                  underrun_reg <= 1'b1;
               end else begin
                  tx_ready_reg <= 1'b1;
               end
               bit_cnt_reg <= '0;
               if (cs_rise) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                  miso_reg  <= 1'b0;
                  oe_reg    <= 1'b0;
               end else begin
                  state_reg <= TRANSFER;
                  miso_reg  <= load_word[DATA_WIDTH-1];
                  oe_reg    <= 1'b1;
               end
            end

            TRANSFER: begin
               if (cs_rise) begin
                  state_reg    <= IDLE;
                  busy_reg     <= 1'b0;
                  miso_reg     <= 1'b0;
                  oe_reg       <= 1'b0;
                  bit_cnt_reg  <= '0;
                  rx_shift_reg <= '0;
               end else if (sample_edge) begin
                  rx_shift_reg <= {rx_shift_reg[DATA_WIDTH-2:0], mosi_bit};
                  bit_cnt_reg  <= bit_cnt_reg + CNT_W'(1);
                  if (bit_cnt_reg == LAST_BIT) begin
                     state_reg <= TRANSFER_END;
                  end
               end else if (shift_edge && (bit_cnt_reg != '0)) begin
                  // Count zero means the MSB is already on the pin from the last load.
                  tx_shift_reg <= {tx_shift_reg[DATA_WIDTH-3:0], 1'b0};
                  miso_reg     <= tx_shift_reg[DATA_WIDTH-2];
               end
            end

            TRANSFER_END: begin
               rx_data_reg  <= rx_shift_reg;
               rx_valid_reg <= 1'b1;
               tx_shift_reg <= load_word[DATA_WIDTH-2:0];
               if (tx_ready_reg) begin
                  underrun_reg <= 1'b1;
               end else begin
                  tx_ready_reg <= 1'b1;
               end
               bit_cnt_reg <= '0;
               if (cs_low) begin
                  state_reg <= TRANSFER;
                  miso_reg  <= load_word[DATA_WIDTH-1];
               end else begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                  miso_reg  <= 1'b0;
                  oe_reg    <= 1'b0;
               end
            end

            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               miso_reg  <= 1'b0;
               oe_reg    <= 1'b0;
            end
         endcase
      end
   end

   assign spi_miso    = miso_reg;
   assign spi_miso_oe = oe_reg;
   assign tx_ready    = tx_ready_reg;
   assign rx_data     = rx_data_reg;
   assign rx_valid    = rx_valid_reg;
   assign busy        = busy_reg;
   assign tx_underrun = underrun_reg;

endmodule

// File: tb/tb_spi_slave.sv
// Drives a mode-0 and a mode-3 spi_slave as an SPI master and checks them
// against a frame-level model of the transmit buffer and receive path.
module tb_spi_slave;
   localparam int W = 8;

   logic PCLK = 1'b0;
   logic PRESETn = 1'b0;
   always #5 PCLK = ~PCLK;

   logic         mosi = 1'b0;
   logic [W-1:0] tx_data = '0;
   logic sclk0 = 1'b0, cs0_n = 1'b1, txv0 = 1'b0;
   logic sclk3 = 1'b1, cs3_n = 1'b1, txv3 = 1'b0;

   logic miso0, oe0, txr0, rxv0, busy0, und0;
   logic miso3, oe3, txr3, rxv3, busy3, und3;
   logic [W-1:0] rxd0, rxd3;

   spi_slave #(.DATA_WIDTH(W), .CPOL(0), .CPHA(0)) u_mode0 (
      .PCLK(PCLK), .PRESETn(PRESETn), .spi_sclk(sclk0), .spi_cs_n(cs0_n),
      .spi_mosi(mosi), .spi_miso(miso0), .spi_miso_oe(oe0), .tx_data(tx_data),
      .tx_valid(txv0), .tx_ready(txr0), .rx_data(rxd0), .rx_valid(rxv0),
      .busy(busy0), .tx_underrun(und0));

   spi_slave #(.DATA_WIDTH(W), .CPOL(1), .CPHA(1)) u_mode3 (
      .PCLK(PCLK), .PRESETn(PRESETn), .spi_sclk(sclk3), .spi_cs_n(cs3_n),
      .spi_mosi(mosi), .spi_miso(miso3), .spi_miso_oe(oe3), .tx_data(tx_data),
      .tx_valid(txv3), .tx_ready(txr3), .rx_data(rxd3), .rx_valid(rxv3),
      .busy(busy3), .tx_underrun(und3));

   // Current device under test: 0 = mode 0, 1 = mode 3.
   bit md = 1'b0;
   int mi = 0;
   logic miso_v, oe_v, txr_v, rxv_v, busy_v, und_v;
   logic [W-1:0] rxd_v;
   assign miso_v = md ? miso3 : miso0;
   assign oe_v   = md ? oe3   : oe0;
   assign txr_v  = md ? txr3  : txr0;
   assign rxv_v  = md ? rxv3  : rxv0;
   assign busy_v = md ? busy3 : busy0;
   assign und_v  = md ? und3  : und0;
   assign rxd_v  = md ? rxd3  : rxd0;

   int rx_cnt [2];
   int und_cnt [2];
   logic [W-1:0] rx_last [2];
   always @(negedge PCLK) begin
      if (rxv0 === 1'b1) begin rx_cnt[0] <= rx_cnt[0] + 1; rx_last[0] <= rxd0; end
      if (rxv3 === 1'b1) begin rx_cnt[1] <= rx_cnt[1] + 1; rx_last[1] <= rxd3; end
      if (und0 === 1'b1) und_cnt[0] <= und_cnt[0] + 1;
      if (und3 === 1'b1) und_cnt[1] <= und_cnt[1] + 1;
   end

   // Reference model: words waiting for the slave, word on the wire, expected counts.
   logic [W-1:0] q0 [$];
   logic [W-1:0] q3 [$];
   logic [W-1:0] cur_tx [2];
   logic [W-1:0] exp_rxd [2];
   int exp_rx [2];
   int exp_und [2];

   int vectors = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s (mode %0d): observed %0h expected %0h", tag, mi * 3, obs, exp);
      end
   endtask

   task automatic set_mode(input bit m3);
      md = m3;
      mi = m3 ? 1 : 0;
   endtask

   task automatic clk(input int n);
      repeat (n) @(negedge PCLK);
   endtask

   task automatic set_sclk(input logic v);
      if (md) sclk3 = v; else sclk0 = v;
   endtask

   task automatic set_cs(input logic v);
      if (md) cs3_n = v; else cs0_n = v;
   endtask

   task automatic set_txv(input logic v);
      if (md) txv3 = v; else txv0 = v;
   endtask

   function automatic logic model_empty();
      return md ? (q3.size() == 0) : (q0.size() == 0);
   endfunction

   task automatic model_push(input logic [W-1:0] d);
      if (md) q3.push_back(d); else q0.push_back(d);
   endtask

   task automatic model_load();
      if (model_empty()) begin
         cur_tx[mi] = '0;
         exp_und[mi]++;
      end else if (md) begin
         cur_tx[mi] = q3.pop_front();
      end else begin
         cur_tx[mi] = q0.pop_front();
      end
   endtask

   task automatic chk_reset_outputs(input string ctx);
      chk({ctx, "_miso"}, miso_v, 1'b0);
      chk({ctx, "_miso_oe"}, oe_v, 1'b0);
      chk({ctx, "_tx_ready"}, txr_v, 1'b1);
      chk({ctx, "_rx_data"}, rxd_v, '0);
      chk({ctx, "_rx_valid"}, rxv_v, 1'b0);
      chk({ctx, "_busy"}, busy_v, 1'b0);
      chk({ctx, "_tx_underrun"}, und_v, 1'b0);
   endtask

   task automatic write_tx(input logic [W-1:0] d);
      @(negedge PCLK);
      chk("tx_ready_before_write", txr_v, model_empty());
      tx_data = d;
      set_txv(1'b1);
      @(negedge PCLK);
      set_txv(1'b0);
      model_push(d);
      chk("tx_ready_after_write", txr_v, 1'b0);
   endtask

   // ending: 0 keep CS low, 1 raise CS, 2 assert reset.
   task automatic frame(input logic [W-1:0] mw, input int nbits, input bit do_fall,
                        input int ending, input bit mid_en, input logic [W-1:0] mid_w,
                        input int half);
      logic [W-1:0] got, exp_tx, mask;
      logic cp;
      cp = md;
      got = '0;
      if (do_fall) begin
         set_cs(1'b0);
         model_load();
      end
      exp_tx = cur_tx[mi];
      for (int i = 0; i < nbits; i++) begin
         if (!cp) mosi = mw[W-1-i];
         if (mid_en && i == 3) begin
            chk("tx_ready_mid_frame", txr_v, model_empty());
            tx_data = mid_w;
            set_txv(1'b1);
            @(negedge PCLK);
            set_txv(1'b0);
            model_push(mid_w);
            clk(half - 1);
         end else begin
            clk(half);
         end
         if (i == 0) chk("miso_oe_in_frame", oe_v, 1'b1);
         set_sclk(~cp);
         if (cp) mosi = mw[W-1-i];
         else    got[W-1-i] = miso_v;
         clk(half);
         set_sclk(cp);
         if (cp) got[W-1-i] = miso_v;
      end
      clk(half);
      if (nbits == W) begin
         model_load();
         exp_rx[mi]++;
         exp_rxd[mi] = mw;
      end
      if (ending == 1) begin
         chk("busy_before_cs_rise", busy_v, 1'b1);
         set_cs(1'b1);
         clk(4);
         chk("busy_after_cs_rise", busy_v, 1'b0);
         chk("miso_oe_after_cs_rise", oe_v, 1'b0);
         chk("miso_after_cs_rise", miso_v, 1'b0);
         clk(6);
      end else if (ending == 2) begin
         PRESETn = 1'b0;
         #1;
         chk_reset_outputs("reset_mid_frame");
         q0.delete();
         q3.delete();
         set_cs(1'b1);
         set_sclk(cp);
         mosi = 1'b0;
         clk(3);
         PRESETn = 1'b1;
         clk(6);
         chk("busy_after_reset_release", busy_v, 1'b0);
      end else begin
         clk(2);
      end
      mask = '1;
      mask = mask << (W - nbits);
      chk("miso_word", got & mask, exp_tx & mask);
      chk("rx_valid_count", rx_cnt[mi], exp_rx[mi]);
      chk("underrun_count", und_cnt[mi], exp_und[mi]);
      if (nbits == W) chk("rx_data", rx_last[mi], exp_rxd[mi]);
      $display("frame mode %0d: mosi %02h bits %0d miso %02h expected %02h rx_valid %0d",
               mi * 3, mw, nbits, got & mask, exp_tx & mask, rx_cnt[mi]);
   endtask

   initial begin
      cur_tx[0] = '0;
      cur_tx[1] = '0;
      clk(2);
      set_mode(1'b0);
      chk_reset_outputs("reset_init");
      set_mode(1'b1);
      chk_reset_outputs("reset_init");
      @(negedge PCLK);
      PRESETn = 1'b1;
      clk(4);

      set_mode(1'b0);
      // Reference transfer: 0xA5 out, 0x3C in.
      write_tx(8'hA5);
      frame(8'h3C, W, 1'b1, 1, 1'b0, '0, 4);
      // No word queued: underrun, zeros on MISO.
      frame(W'($urandom), W, 1'b1, 1, 1'b0, '0, 4);
      // Two frames under one CS, second word written during the first.
      write_tx(8'h12);
      frame(W'($urandom), W, 1'b1, 0, 1'b1, 8'h34, 4);
      frame(W'($urandom), W, 1'b0, 1, 1'b0, '0, 4);
      // Aborted after five bits, then a clean frame.
      write_tx(W'($urandom));
      frame(W'($urandom), 5, 1'b1, 1, 1'b0, '0, 4);
      write_tx(W'($urandom));
      frame(W'($urandom), W, 1'b1, 1, 1'b0, '0, 4);
      // Reset mid-frame, then a clean frame.
      write_tx(W'($urandom));
      frame(W'($urandom), 4, 1'b1, 2, 1'b0, '0, 4);
      write_tx(W'($urandom));
      frame(W'($urandom), W, 1'b1, 1, 1'b0, '0, 4);

      set_mode(1'b1);
      write_tx(8'h81);
      frame(8'h7E, W, 1'b1, 1, 1'b0, '0, 4);
      frame(W'($urandom), W, 1'b1, 1, 1'b0, '0, 5);
      write_tx(8'h12);
      frame(W'($urandom), W, 1'b1, 0, 1'b1, 8'h34, 4);
      frame(W'($urandom), W, 1'b0, 1, 1'b0, '0, 4);

      for (int k = 0; k < 12; k++) begin
         set_mode(k[0]);
         if ($urandom_range(0, 3) != 0 && model_empty()) write_tx(W'($urandom));
         frame(W'($urandom), W, 1'b1, 1, 1'b0, '0, $urandom_range(4, 6));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
